// File: rtl/alu_functional_unit_pkg.sv
// Shared types for the ALU functional unit: opcode encoding, FU state, multiplier latency.
// The Mul opcode only executes when ALU_MUL_EN is defined.
package alu_functional_unit_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSlt  = 4'd5,
    AluSltu = 4'd6,
    AluSll  = 4'd7,
    AluSrl  = 4'd8,
    AluSra  = 4'd9,
    AluMul  = 4'd10
  } alu_func_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } fu_state_e;

  localparam int unsigned MUL_LATENCY = 4;

endpackage

// File: rtl/alu_functional_unit_if.sv
// Issue and CDB signals between the reservation station / CDB arbiter (master)
// and the ALU functional unit (slave).
interface alu_functional_unit_if;

  logic        valid_in;
  logic [31:0] rval1_in;
  logic [31:0] rval2_in;
  logic [3:0]  opcode_in;
  logic [2:0]  rob_idx_in;
  logic        fu_busy;
  logic        cdb_grant_in;
  logic        cdb_req_out;
  logic        cdb_valid_out;
  logic [2:0]  cdb_rob_idx_out;
  logic [31:0] cdb_value_out;

  modport master (
    output valid_in, rval1_in, rval2_in, opcode_in, rob_idx_in, cdb_grant_in,
    input  fu_busy, cdb_req_out, cdb_valid_out, cdb_rob_idx_out, cdb_value_out
  );

  modport slave (
    input  valid_in, rval1_in, rval2_in, opcode_in, rob_idx_in, cdb_grant_in,
    output fu_busy, cdb_req_out, cdb_valid_out, cdb_rob_idx_out, cdb_value_out
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath. The multiplier exists only when ALU_MUL_EN is defined;
// otherwise opcode 10 falls into the undefined-opcode path and yields 0.
module alu_core
  import alu_functional_unit_pkg::*;
(
  input  logic [31:0] i_rval1,
  input  logic [31:0] i_rval2,
  input  logic [3:0]  i_opcode,
  output logic [31:0] o_result
);

  logic [4:0] w_shamt;

  assign w_shamt = i_rval2[4:0];

  always_comb begin
    o_result = '0;
    case (i_opcode)
      AluAdd:  o_result = i_rval1 + i_rval2;
      AluSub:  o_result = i_rval1 - i_rval2;
      AluAnd:  o_result = i_rval1 & i_rval2;
      AluOr:   o_result = i_rval1 | i_rval2;
      AluXor:  o_result = i_rval1 ^ i_rval2;
      AluSlt:  o_result = {31'd0, $signed(i_rval1) < $signed(i_rval2)};
      AluSltu: o_result = {31'd0, i_rval1 < i_rval2};
      AluSll:  o_result = i_rval1 << w_shamt;
      AluSrl:  o_result = i_rval1 >> w_shamt;
      AluSra:  o_result = $unsigned($signed(i_rval1) >>> w_shamt);
`ifdef ALU_MUL_EN
      AluMul:  o_result = i_rval1 * i_rval2;
`endif
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_functional_unit.sv
// ALU functional unit: issue from the reservation station, hold the result until the CDB grants.
// Define ALU_MUL_EN to enable the multi-cycle Mul path (IDLE -> EXEC -> DONE).
module alu_functional_unit
  import alu_functional_unit_pkg::*;
(
  input logic                  clk_in,
  input logic                  rst_in,
  alu_functional_unit_if.slave fu_if
);

  fu_state_e   r_state;
  fu_state_e   w_state_next;
  logic [31:0] r_value;
  logic [31:0] w_result;
  logic [2:0]  r_rob_idx;
  logic        w_issue;
  logic        w_is_mul;
  logic        w_cnt_done;
  logic        w_req;

  alu_core u_alu_core (
    .i_rval1  (fu_if.rval1_in),
    .i_rval2  (fu_if.rval2_in),
    .i_opcode (fu_if.opcode_in),
    .o_result (w_result)
  );

  assign w_issue = (r_state == StIdle) && fu_if.valid_in;

`ifdef ALU_MUL_EN
  localparam int unsigned CntWidth = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(MUL_LATENCY - 1);

  logic [CntWidth-1:0] r_cnt;

  assign w_is_mul   = (fu_if.opcode_in == AluMul);
  assign w_cnt_done = (r_cnt == CntLast);

  // Counts EXEC cycles; the product itself is captured at issue.
  always_ff @(posedge clk_in) begin
    if (rst_in || (r_state != StExec)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_cnt_done = 1'b1;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= StIdle;
      r_value   <= '0;
      r_rob_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_issue) begin
        r_value   <= w_result;
        r_rob_idx <= fu_if.rob_idx_in;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (fu_if.valid_in) begin
          w_state_next = w_is_mul ? StExec : StDone;
        end
      end
      StExec: begin
        if (w_cnt_done) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (fu_if.cdb_grant_in) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs are forced quiet while reset is asserted so a pending result is never broadcast.
  always_comb begin
    w_req                 = (r_state == StDone) && !rst_in;
    fu_if.fu_busy         = ((r_state != StIdle) && !rst_in) || fu_if.valid_in;
    fu_if.cdb_req_out     = w_req;
    fu_if.cdb_valid_out   = w_req && fu_if.cdb_grant_in;
    fu_if.cdb_rob_idx_out = rst_in ? 3'd0 : r_rob_idx;
    fu_if.cdb_value_out   = rst_in ? 32'd0 : r_value;
  end

endmodule
